// File: rtl/dr_link_tx.sv
// Dual-rail link transmitter: two-phase ("TP") or four-phase RTZ ("FP") encoding.
// Defining DR_LINK_TX_BUF_EN adds a one-word holding register so a word can queue while busy.
`timescale 1ns/1ps
module dr_link_tx #(
   parameter            ENC      = "TP",
   parameter int        WIDTH    = 1,
   localparam int       RAIL_NUM = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   input  logic                           ack_i,
   output logic [WIDTH-1:0][RAIL_NUM-1:0] out,
   output logic                           busy
);
   localparam bit FP = (ENC == "FP");

   typedef enum logic [1:0] {StIdle, StWaitAck, StWaitRtz} state_e;

   state_e                         r_state, w_state_d;
   logic [WIDTH-1:0][RAIL_NUM-1:0] r_out, w_out_d;
   logic                           r_ack_exp, w_ack_exp_d;
   logic                           r_ack_m, r_ack_s;
   logic                           r_init;
   logic                           w_xfer, w_done, w_free, w_launch;
   logic [WIDTH-1:0]               w_word;

   // ack_i is asynchronous to clk; only r_ack_s is used downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack_m <= 1'b0;
         r_ack_s <= 1'b0;
         r_init  <= 1'b0;
      end else begin
         r_ack_m <= ack_i;
         r_ack_s <= r_ack_m;
         r_init  <= 1'b1;
      end
   end

   // w_done: the handshake of the current token completes on this edge.
   always_comb begin
      w_done = 1'b0;
      unique case (r_state)
         StWaitAck: w_done = !FP && (r_ack_s == r_ack_exp);
         StWaitRtz: w_done = !r_ack_s;
         default:   w_done = 1'b0;
      endcase
   end

   assign w_free = (r_state == StIdle) || w_done;

`ifdef DR_LINK_TX_BUF_EN
   logic             r_buf_full;
   logic [WIDTH-1:0] r_buf_data;

   assign in_ready = r_init && !r_buf_full;
   assign w_xfer   = in_valid && in_ready;
   // A held word launches on the completion edge itself, so the link never idles between words.
   assign w_launch = w_free && (r_buf_full || w_xfer);
   assign w_word   = r_buf_full ? r_buf_data : in_data;
   assign busy     = (r_state != StIdle) || r_buf_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_full <= 1'b0;
         r_buf_data <= '0;
      end else if (w_xfer && !w_free) begin
         r_buf_full <= 1'b1;
         r_buf_data <= in_data;
      end else if (w_launch) begin
         r_buf_full <= 1'b0;
      end
   end
`else
   assign in_ready = r_init && (r_state == StIdle);
   assign w_xfer   = in_valid && in_ready;
   assign w_launch = w_xfer && w_free;
   assign w_word   = in_data;
   assign busy     = (r_state != StIdle);
`endif

   always_comb begin
      w_state_d   = r_state;
      w_out_d     = r_out;
      w_ack_exp_d = r_ack_exp;
      if (w_launch) begin
         w_state_d = StWaitAck;
         for (int i = 0; i < WIDTH; i++) begin
            if (FP) begin
               w_out_d[i] = w_word[i] ? 2'b10 : 2'b01;
            end else begin
               w_out_d[i] = r_out[i] ^ (w_word[i] ? 2'b10 : 2'b01);
            end
         end
         if (!FP) begin
            w_ack_exp_d = !r_ack_exp;
         end
      end else if (w_done) begin
         w_state_d = StIdle;
      end else if (FP && (r_state == StWaitAck) && r_ack_s) begin
         // Receiver took the codeword: return every rail to zero.
         w_state_d = StWaitRtz;
         w_out_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_out     <= '0;
         r_ack_exp <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_out     <= w_out_d;
         r_ack_exp <= w_ack_exp_d;
      end
   end

   assign out = r_out;

endmodule

// File: doc/dr_link_tx.md
DR_LINK_TX -- requirements
Module: dr_link_tx

Interface
REQ-001 Parameter ENC, default "TP", selects link encoding: "TP" two-phase transition dual-rail, "FP" four-phase return-to-zero dual-rail.
REQ-002 Parameter WIDTH, default 1, sets the number of data bits per token.
REQ-003 Localparam RAIL_NUM, fixed 2, sets the rails per bit.
REQ-004 Port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-006 Port in_valid, input, 1 bit, synchronous source presents a word.
REQ-007 Port in_ready, output, 1 bit, block can accept a word this cycle.
REQ-008 Port in_data, input, WIDTH bits, word to transmit.
REQ-009 Port ack_i, input, 1 bit, asynchronous acknowledge from the link receiver.
REQ-010 Port out, output, [WIDTH-1:0][RAIL_NUM-1:0], dual-rail link driven by a register.
REQ-011 Port busy, output, 1 bit, a token or spacer is outstanding on the link.

Function
REQ-012 ack_i SHALL pass through a 2-flop synchronizer (ack_s) before any use; no other logic samples ack_i directly.
REQ-013 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-014 FSM states SHALL be IDLE, WAIT_ACK and WAIT_RTZ; WAIT_RTZ is reachable only when ENC="FP".
REQ-015 in_ready SHALL be 1 only in IDLE when DR_LINK_TX_BUF_EN is undefined.
REQ-016 TP: on a transfer, for each bit i, out[i][1] SHALL toggle if in_data[i]=1 and out[i][0] SHALL toggle otherwise. Expected-ack phase ack_exp SHALL toggle, and the FSM SHALL go to WAIT_ACK.
REQ-017 TP: WAIT_ACK SHALL go to IDLE on the first edge where ack_s==ack_exp.
REQ-018 FP: on a transfer, out[i] SHALL be loaded with 2'b10 for in_data[i]=1 and 2'b01 for in_data[i]=0, and the FSM SHALL go to WAIT_ACK.
REQ-019 FP: WAIT_ACK SHALL go to WAIT_RTZ when ack_s==1, loading out with all zeros (spacer) on that edge.
REQ-020 FP: WAIT_RTZ SHALL go to IDLE when ack_s==0.
REQ-021 out SHALL change only on the transfer edge or the spacer edge, and never with both rails of a bit changing on one edge.
REQ-022 Codeword latency SHALL be 0 cycles: out carries the token immediately after the accepting edge.
REQ-023 Minimum token period SHALL be 4 cycles in TP (accept, 2 sync, return) with immediate ack; in FP it SHALL be 7 cycles.
REQ-024 busy SHALL be 1 in WAIT_ACK and WAIT_RTZ, and also while the buffer holds a word.
REQ-025 An ack_i edge arriving in IDLE SHALL be ignored in FP and SHALL NOT advance state; a TP ack mismatch persists until it matches.

Reset
REQ-026 rst=1 SHALL immediately clear: out=0 on every rail, FSM=IDLE, ack_exp=0, synchronizer flops=0, buffer empty, in_ready=0, busy=0.
REQ-027 in_ready SHALL rise on the first edge after rst deasserts.
REQ-028 Reset mid-token SHALL abandon the token; the receiver must be reset concurrently, and no recovery handshake is performed.

Configuration
REQ-029 Macro DR_LINK_TX_BUF_EN, when defined, SHALL add a one-entry holding register: in_ready equals buffer-not-full, and an accepted word is buffered while the link is busy, then launched on the edge the FSM enters IDLE, with no idle cycle in between.
REQ-030 Without DR_LINK_TX_BUF_EN, no holding register SHALL exist and REQ-015 SHALL apply.

Verification
REQ-031 TP, WIDTH=4: send 4'hA from reset, then ack_i toggles to 1 -> out goes from 0 to bits3..0 rails 10,01,10,01; in_ready=1 returns 3 cycles after ack_i rises.
REQ-032 TP: send 4'hA then 4'hA again with ack_i toggling 1 then 0 -> out returns to all zeros after the second token; ack_exp=0.
REQ-033 FP, WIDTH=2: send 2'b01 -> out=01/10 (bit1/bit0); ack_i=1 -> out=0 spacer; ack_i=0 -> IDLE; total token period 7 cycles with 1-cycle ack turnaround.
REQ-034 Hold ack_i low after sending -> out and busy=1 stay stable for 100 cycles; in_ready=0 (no BUF) or 1 then 0 after one more accept (BUF).
REQ-035 Assert rst in WAIT_ACK -> out=0 and busy=0 asynchronously, before the next clk edge.
REQ-036 With DR_LINK_TX_BUF_EN, issue back-to-back in_valid for 3 words, ack after 2 cycles each -> all 3 words appear in order, with no word dropped or duplicated.
